// File: rtl/md_unit_pkg.sv
// Shared multiply/divide encodings and default latencies for the EX-stage MD unit,
// the decoder and hazard control.
package md_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd5;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic md_op_is_multi(input logic [MD_OP_W-1:0] op);
    return (op <= MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// MIPS multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU, HI/LO registers,
// MTHI/MTLO writes and the MFHI/MFLO read mux.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi_lo_out
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    op_a_q, op_a_d;
  logic [XLEN-1:0]    op_b_q, op_b_d;
  logic               sgn_q, sgn_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [2*XLEN-1:0]  a_ext, b_ext, prod;
  logic               neg_a, neg_b, div_zero;
  logic [XLEN-1:0]    mag_a, mag_b, mag_b_safe;
  logic [XLEN-1:0]    quo_mag, rem_mag, quo, rem;

  // Product: extension picks signed vs unsigned, low 64 bits are exact for both.
  always_comb begin
    a_ext = {{XLEN{sgn_q & op_a_q[XLEN-1]}}, op_a_q};
    b_ext = {{XLEN{sgn_q & op_b_q[XLEN-1]}}, op_b_q};
    prod  = a_ext * b_ext;
  end

  // Quotient/remainder via magnitudes; divisor 0 is replaced so no X propagates.
  always_comb begin
    neg_a      = sgn_q & op_a_q[XLEN-1];
    neg_b      = sgn_q & op_b_q[XLEN-1];
    mag_a      = neg_a ? (~op_a_q + XLEN'(1)) : op_a_q;
    mag_b      = neg_b ? (~op_b_q + XLEN'(1)) : op_b_q;
    div_zero   = (op_b_q == '0);
    mag_b_safe = div_zero ? XLEN'(1) : mag_b;
    quo_mag    = mag_a / mag_b_safe;
    rem_mag    = mag_a % mag_b_safe;
    quo        = (neg_a ^ neg_b) ? (~quo_mag + XLEN'(1)) : quo_mag;
    rem        = neg_a ? (~rem_mag + XLEN'(1)) : rem_mag;
  end

  // Next-state, operand latching and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (md_op)
            MD_OP_MULT, MD_OP_MULTU: begin
              op_a_d  = rs_val;
              op_b_d  = rt_val;
              sgn_d   = (md_op == MD_OP_MULT);
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = ST_MUL;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              op_a_d  = rs_val;
              op_b_d  = rt_val;
              sgn_d   = (md_op == MD_OP_DIV);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = ST_DIV;
            end
            MD_OP_MTHI: hi_d = rs_val;
            MD_OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[2*XLEN-1:XLEN];
          lo_d    = prod[XLEN-1:0];
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) begin
          if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Stall also covers the issue cycle, before busy has risen.
  assign busy      = busy_q;
  assign md_stall  = busy_q | (start & md_op_is_multi(md_op));
  assign hi_lo_out = rd_hi ? hi_q : lo_q;

endmodule
